// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the byte-wide UART transmitter:
//   - uart_state_e        : transmitter FSM states
//   - CLKS_PER_BIT_DEFAULT: 100 MHz / 115200 baud
//   - frame bit counts    : 8N1 frame and the optional parity frame
//   - even_parity()       : XOR-reduction of a data byte
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned FRAME_BITS_8N1    = 10;
    localparam int unsigned FRAME_BITS_PARITY = 11;

    // Index of the final data bit; the DATA state leaves after this one.
    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; bit_tick is high
// for the single cycle in which the count equals CLKS_PER_BIT-1, i.e. the
// final cycle of every serial bit.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  hold the count at 0 (used while the transmitter is idle)
//   bit_tick out last cycle of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    // Width covers 0..CLKS_PER_BIT-1; never narrower than one bit.
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: cleared while idle, wraps at every bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);

endmodule : uart_baud_gen

// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
// Byte-wide UART transmitter. Accepts one byte per valid handshake while
// idle and shifts it out LSB first as an 8N1 frame (start, 8 data, stop).
// tx_done pulses for one cycle as the line returns to idle.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   valid    in  data_in is offered for transmission (only looked at in idle)
//   data_in  in  byte to send, latched on acceptance
//   tx       out serial line, idle high (registered)
//   tx_done  out one-cycle pulse, frame fully sent (registered)
//   busy     out frame in progress (registered)
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit (11-bit frame).
// ---------------------------------------------------------------------------
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_done,
    output logic       busy
);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        tx_q;
    logic        tx_d;
    logic        tx_done_q;
    logic        tx_done_d;
    logic        busy_q;
    logic        busy_d;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // consumed by the time the parity bit goes out.
    logic        parity_q;
    logic        parity_d;
`endif

    logic        bit_tick_s;
    logic        baud_clear_s;

    // Holding the counter clear in idle means the first bit period starts
    // counting from 0 in the cycle right after acceptance.
    assign baud_clear_s = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that the registered tx/busy/tx_done change on the same edge
    // as the state they describe.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // valid is only sampled here. The edge that finishes the
                // stop bit (and raises tx_done) is still in STOP, so a
                // stale valid held across that edge cannot restart a frame.
                if (valid) begin
                    shift_d = data_in;
                    idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(data_in);
`endif
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (bit_tick_s) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tx_d    = 1'b0;
                end
            end

            ST_DATA: begin
                if (bit_tick_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Next data bit is the one about to reach bit 0.
                        tx_d    = shift_q[1];
                    end
                end else begin
                    tx_d = shift_q[0];
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d    = parity_q;
                end
            end
`endif

            ST_STOP: begin
                if (bit_tick_s) begin
                    state_d   = ST_IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    tx_done_d = 1'b1;
                end else begin
                    tx_d      = 1'b1;
                end
            end

            default: begin
                // Unreachable encodings recover to a quiet idle line.
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            idx_q     <= 3'd0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_done = tx_done_q;
    assign busy    = busy_q;

endmodule : uart_byte_tx

// File: tb/tb_uart_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_tx
// Self-checking bench for uart_byte_tx with CLKS_PER_BIT = 4. The expected
// line waveform of each frame is built from the byte as a list of frame bits
// (start, data LSB first, optional even parity, stop); each bit lasts CPB
// cycles, tx_done/busy follow from the frame length.
// ---------------------------------------------------------------------------
module tb_uart_byte_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    // Stimulus modes applied during a frame
    localparam int M_DROP   = 0;  // valid low after acceptance
    localparam int M_TOGGLE = 1;  // controller pattern 1,1,0,...
    localparam int M_FF     = 2;  // data_in forced to 0xFF, valid random
    localparam int M_RAND   = 3;  // random valid and data_in
    localparam int M_HOLD   = 4;  // valid and data_in held steady

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       valid   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       tx_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic exp_bits[$];

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .data_in (data_in),
        .tx      (tx),
        .tx_done (tx_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bits of a byte as they should appear on the line.
    function automatic void build_frame(input logic [7:0] b);
        int ones;
        logic bitv;
        ones = 0;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bitv = ((b >> i) & 8'h01) != 8'h00;
            exp_bits.push_back(bitv);
            if (bitv) ones++;
        end
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back((ones % 2) == 1);
`endif
        exp_bits.push_back(1'b1);
    endfunction

    // Idle line for n cycles; entered and left at a falling edge.
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_value("idle_tx", tx, 1'b1);
            check_value("idle_busy", busy, 1'b0);
            check_value("idle_done", tx_done, 1'b0);
        end
    endtask

    // Offer byte b (caller sits at a falling edge), then check every cycle
    // of the frame through the tx_done cycle. abort_at >= 0 pulls rst_n low
    // at that cycle and checks the asynchronous return to idle.
    task automatic send_frame(input logic [7:0] b, input int mode,
                              input int abort_at);
        build_frame(b);
        data_in = b;
        valid   = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= FLEN; k++) begin
            @(negedge clk);
            if (k < FLEN) begin
                check_value($sformatf("tx_%02h_c%0d", b, k), tx, exp_bits[k / CPB]);
                check_value($sformatf("busy_%02h_c%0d", b, k), busy, 1'b1);
                check_value($sformatf("done_%02h_c%0d", b, k), tx_done, 1'b0);
            end else begin
                check_value($sformatf("tx_end_%02h", b), tx, 1'b1);
                check_value($sformatf("busy_end_%02h", b), busy, 1'b0);
                check_value($sformatf("done_end_%02h", b), tx_done, 1'b1);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_value("rst_tx", tx, 1'b1);
                check_value("rst_busy", busy, 1'b0);
                check_value("rst_done", tx_done, 1'b0);
                return;
            end
            case (mode)
                M_DROP:   valid = 1'b0;
                M_TOGGLE: valid = ((k % 3) != 2);
                M_FF: begin
                    valid   = 1'($urandom_range(0, 1));
                    data_in = 8'hFF;
                end
                M_RAND: begin
                    valid   = 1'($urandom_range(0, 1));
                    data_in = 8'($urandom);
                end
                default: valid = 1'b1;
            endcase
            if (k == FLEN && mode != M_HOLD) begin
                valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         rmode;
        int         rgap;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("reset_tx", tx, 1'b1);
        check_value("reset_busy", busy, 1'b0);
        check_value("reset_done", tx_done, 1'b0);
        rst_n = 1'b1;
        idle_check(2);

        // Plain frame, alternating bits
        send_frame(8'h55, M_DROP, -1);
        idle_check(3);

        // Repeated controller valid pulses: one frame only
        send_frame(8'hA5, M_TOGGLE, -1);
        idle_check(4);

        // data_in changed mid-frame: latched byte unaffected
        send_frame(8'h3C, M_FF, -1);
        idle_check(2);

        // valid held high: back-to-back frames, one idle cycle apart
        send_frame(8'h11, M_HOLD, -1);
        send_frame(8'h22, M_DROP, -1);
        idle_check(2);

        // Reset during data bit 3, then a clean frame
        send_frame(8'hC3, M_DROP, 4 * CPB + 1);
        @(negedge clk);
        check_value("rst_hold_tx", tx, 1'b1);
        check_value("rst_hold_done", tx_done, 1'b0);
        rst_n = 1'b1;
        idle_check(3);
        send_frame(8'h81, M_DROP, -1);
        idle_check(2);

`ifdef UART_TX_PARITY_EN
        // Odd number of ones gives parity 1, even gives 0
        send_frame(8'h07, M_DROP, -1);
        idle_check(1);
        send_frame(8'h03, M_DROP, -1);
        idle_check(1);
`endif

        // Randomized frames, modes and gaps (gap 0 = back-to-back)
        for (int n = 0; n < 24; n++) begin
            rb    = 8'($urandom);
            rmode = $urandom_range(0, 3);
            rgap  = $urandom_range(0, 3);
            send_frame(rb, rmode, -1);
            if (rgap > 0) idle_check(rgap);
        end
        idle_check(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_uart_byte_tx
